// File: rtl/apb_audio_regif_pkg.sv
// Audioport register map, command bit positions and register decode helper.
package apb_audio_regif_pkg;

  localparam logic [11:0] CMD_OFFSET    = 12'h000;
  localparam logic [11:0] STATUS_OFFSET = 12'h004;
  localparam logic [11:0] LEVEL_OFFSET  = 12'h008;
  localparam logic [11:0] FIFO_OFFSET   = 12'h00C;

  localparam int unsigned CMD_START_BIT = 0;
  localparam int unsigned CMD_STOP_BIT  = 1;
  localparam int unsigned CMD_CLR_BIT   = 2;

  localparam logic [15:0] LEVEL_RESET = 16'h8000;

  typedef enum logic [2:0] {
    SelCmd,
    SelStatus,
    SelLevel,
    SelFifo,
    SelRsvd
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [11:0] offset);
    reg_sel_e sel;
    unique case (offset)
      CMD_OFFSET:    sel = SelCmd;
      STATUS_OFFSET: sel = SelStatus;
      LEVEL_OFFSET:  sel = SelLevel;
      FIFO_OFFSET:   sel = SelFifo;
      default:       sel = SelRsvd;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb_pkg.sv
// Shared APB constants: the DUT address window and bus timing parameters.
package apb_pkg;

  localparam logic [31:0] DUT_START_ADDRESS   = 32'h8c00_0000;
  localparam logic [31:0] DUT_END_ADDRESS     = 32'h8c00_0598;
  localparam int unsigned APB_MAX_WAIT_STATES = 0;
  localparam int unsigned APB_INPUT_DELAY     = 1;

endpackage

// File: rtl/sample_fifo.sv
// Circular sample FIFO with push/pop/clear; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_clr,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty & ~i_clr;
  assign w_push_ok = i_push & (~o_full | w_pop_ok) & ~i_clr;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_audio_regif.sv
// APB3 register front end of the audioport: command/status/level registers
// and an APB-fed sample FIFO drained by the sample processor.
module apb_audio_regif
  import apb_pkg::*;
  import apb_audio_regif_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PSEL_in,
  input  logic                  PENABLE_in,
  input  logic                  PWRITE_in,
  input  logic [31:0]           PADDR_in,
  input  logic [DATA_WIDTH-1:0] PWDATA_in,
  output logic [DATA_WIDTH-1:0] PRDATA_out,
  output logic                  PREADY_out,
  output logic                  PSLVERR_out,
  output logic                  start_out,
  output logic                  stop_out,
  output logic [15:0]           level_out,
  input  logic                  sample_req_in,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_ack_out,
  output logic                  fifo_empty_out
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                  r_play;
  logic                  r_start;
  logic                  r_stop;
  logic                  r_clr;
  logic [15:0]           r_level;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_sample;

  logic                  w_access;
  logic                  w_in_win;
  logic [11:0]           w_offset;
  reg_sel_e              w_sel;
  logic                  w_err;
  logic                  w_commit;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_cmd_wr;
  logic [DATA_WIDTH-1:0] w_head;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_status;

  assign w_access = PSEL_in & PENABLE_in;
  assign w_in_win = (PADDR_in >= DUT_START_ADDRESS) && (PADDR_in <= DUT_END_ADDRESS);
  assign w_offset = PADDR_in[11:0] - DUT_START_ADDRESS[11:0];
  assign w_sel    = decode_reg(w_offset);

  // A pending clear discards any pop in its cycle, so no ack is produced.
  assign w_pop = sample_req_in & ~w_empty & r_play & ~r_clr;

  assign w_err = ~w_in_win
               | (PWRITE_in & (w_sel == SelStatus))
               | (~PWRITE_in & ((w_sel == SelCmd) | (w_sel == SelFifo)))
               | (PWRITE_in & (w_sel == SelFifo) & w_full & ~w_pop);

  assign w_commit = w_access & PWRITE_in & ~w_err;
  assign w_push   = w_commit & (w_sel == SelFifo);
  assign w_cmd_wr = w_commit & (w_sel == SelCmd);

  assign PREADY_out  = w_access;
  assign PSLVERR_out = w_access & w_err;

  always_comb begin
    w_status            = '0;
    w_status[0]         = r_play;
    w_status[8 +: CW]   = w_count;
    w_status[16]        = w_full;
  end

  always_comb begin
    PRDATA_out = '0;
    if (w_access && !PWRITE_in && !w_err) begin
      unique case (w_sel)
        SelStatus: PRDATA_out = w_status;
        SelLevel:  PRDATA_out = {{(DATA_WIDTH - 16){1'b0}}, r_level};
        default:   PRDATA_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_play   <= 1'b0;
      r_start  <= 1'b0;
      r_stop   <= 1'b0;
      r_clr    <= 1'b0;
      r_level  <= LEVEL_RESET;
      r_ack    <= 1'b0;
      r_sample <= '0;
    end else begin
      r_start <= w_cmd_wr & PWDATA_in[CMD_START_BIT] & ~PWDATA_in[CMD_STOP_BIT];
      r_stop  <= w_cmd_wr & PWDATA_in[CMD_STOP_BIT];
      r_clr   <= w_cmd_wr & PWDATA_in[CMD_CLR_BIT];
      if (w_cmd_wr) begin
        if (PWDATA_in[CMD_STOP_BIT]) begin
          r_play <= 1'b0;
        end else if (PWDATA_in[CMD_START_BIT]) begin
          r_play <= 1'b1;
        end
      end
      if (w_commit && (w_sel == SelLevel)) begin
        r_level <= PWDATA_in[15:0];
      end
      r_ack <= w_pop;
      if (w_pop) begin
        r_sample <= w_head;
      end
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (PWDATA_in),
    .i_pop   (w_pop),
    .i_clr   (r_clr),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign start_out      = r_start;
  assign stop_out       = r_stop;
  assign level_out      = r_level;
  assign sample_out     = r_sample;
  assign sample_ack_out = r_ack;
  assign fifo_empty_out = w_empty;

endmodule

// File: tb/tb_apb_audio_regif.sv
// Scoreboard bench: a queue-based behavioural model predicts APB responses and
// popped samples; a negedge monitor compares whatever the DUT presents.
module tb_apb_audio_regif;
  import apb_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] A_CMD    = DUT_START_ADDRESS + 32'h0;
  localparam logic [31:0] A_STATUS = DUT_START_ADDRESS + 32'h4;
  localparam logic [31:0] A_LEVEL  = DUT_START_ADDRESS + 32'h8;
  localparam logic [31:0] A_FIFO   = DUT_START_ADDRESS + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, req = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata, sample;
  logic        pready, pslverr, start_p, stop_p, ack, empty;
  logic [15:0] level;

  always #5 clk = ~clk;

  apb_audio_regif #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PSEL_in        (psel),
    .PENABLE_in     (penable),
    .PWRITE_in      (pwrite),
    .PADDR_in       (paddr),
    .PWDATA_in      (pwdata),
    .PRDATA_out     (prdata),
    .PREADY_out     (pready),
    .PSLVERR_out    (pslverr),
    .start_out      (start_p),
    .stop_out       (stop_p),
    .level_out      (level),
    .sample_req_in  (req),
    .sample_out     (sample),
    .sample_ack_out (ack),
    .fifo_empty_out (empty)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mq[$];        // model FIFO contents, head first
  logic [31:0] exp_samp[$];  // samples the model says were popped
  resp_t       apb_exp[$];
  bit          m_play = 0, m_clr_pend = 0, m_start = 0, m_stop = 0;
  logic [15:0] m_level = 16'h8000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic bit m_pop_now();
    return req && m_play && (mq.size() != 0) && !m_clr_pend;
  endfunction

  function automatic bit m_err(input bit wr, input logic [31:0] a, input bit pop);
    logic [31:0] off;
    if (a < DUT_START_ADDRESS || a > DUT_END_ADDRESS) return 1'b1;
    off = a - DUT_START_ADDRESS;
    if (wr && off == 32'h4) return 1'b1;
    if (!wr && (off == 32'h0 || off == 32'hC)) return 1'b1;
    if (wr && off == 32'hC && mq.size() >= DEPTH && !pop) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    logic [31:0] off;
    int          n;
    off = a - DUT_START_ADDRESS;
    n   = mq.size();
    if (off == 32'h4) return 32'(m_play) + 32'(n * 256) + ((n == DEPTH) ? 32'h1_0000 : 32'h0);
    if (off == 32'h8) return {16'h0, m_level};
    return 32'h0;
  endfunction

  // Reference model: advances at every rising edge from the stimulus inputs.
  bit          mp_pop, mp_err, mp_commit;
  logic [31:0] mp_off;
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      exp_samp.delete();
      m_play = 0; m_clr_pend = 0; m_start = 0; m_stop = 0;
      m_level = 16'h8000;
    end else begin
      mp_pop    = m_pop_now();
      mp_err    = m_err(pwrite, paddr, mp_pop);
      mp_commit = psel && penable && pwrite && !mp_err;
      mp_off    = paddr - DUT_START_ADDRESS;
      m_start   = 0;
      m_stop    = 0;
      if (m_clr_pend) begin
        mq.delete();
        m_clr_pend = 0;
      end else begin
        if (mp_pop) exp_samp.push_back(mq.pop_front());
        if (mp_commit && mp_off == 32'hC) mq.push_back(pwdata);
      end
      if (mp_commit && mp_off == 32'h0) begin
        m_stop  = pwdata[1];
        m_start = pwdata[0] && !pwdata[1];
        if (pwdata[1]) m_play = 0;
        else if (pwdata[0]) m_play = 1;
        m_clr_pend = pwdata[2];
      end
      if (mp_commit && mp_off == 32'h8) m_level = pwdata[15:0];
    end
  end

  // Monitor
  resp_t mr;
  always @(negedge clk) begin
    chk("start_out", start_p, m_start);
    chk("stop_out", stop_p, m_stop);
    chk("level_out", level, m_level);
    chk("fifo_empty_out", empty, mq.size() == 0);
    if (psel && penable) begin
      chk("pready", pready, 1'b1);
      if (apb_exp.size() == 0) fail_now("apb_unexpected_access");
      else begin
        mr = apb_exp.pop_front();
        chk("pslverr", pslverr, mr.err);
        chk("prdata", prdata, mr.rdata);
      end
    end else begin
      chk("prdata_idle", prdata, 32'h0);
    end
    if (ack) begin
      if (exp_samp.size() == 0) fail_now("sample_ack_unexpected");
      else chk("sample_out", sample, exp_samp.pop_front());
    end
    if (exp_samp.size() != 0) begin
      fail_now("sample_ack_missing");
      exp_samp.delete();
    end
  end

  // Starts and ends just after a rising edge; predicts the response in the access phase.
  task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input bit rq_s, input bit rq_a);
    resp_t r;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; req = rq_s;
    @(posedge clk); #1;
    penable = 1; req = rq_a;
    r.err   = m_err(wr, a, m_pop_now());
    r.rdata = (wr || r.err) ? 32'h0 : m_rdata(a);
    apb_exp.push_back(r);
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic idle(input int n, input bit rq);
    repeat (n) begin
      req = rq;
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int i;
    req = 1;
    for (i = 0; i < 60 && mq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (mq.size() != 0) fail_now("drain_timeout");
    idle(2, 1'b0);
  endtask

  logic [31:0] rand_addr[9];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    apb(0, A_STATUS, 0, 0, 0);
    apb(0, A_LEVEL, 0, 0, 0);
    apb(1, A_LEVEL, 32'h1234, 0, 0);
    apb(0, A_LEVEL, 0, 0, 0);
    apb(1, A_STATUS, 32'hFFFF_FFFF, 0, 0);
    apb(0, A_STATUS, 0, 0, 0);

    for (int i = 0; i < 16; i++) apb(1, A_FIFO, 32'hA0 + i, 0, 0);
    apb(0, A_STATUS, 0, 0, 0);
    apb(1, A_FIFO, 32'hB0, 0, 0);
    apb(0, A_STATUS, 0, 0, 0);

    apb(1, A_CMD, 32'h1, 0, 0);
    apb(0, A_STATUS, 0, 0, 0);
    apb(1, A_FIFO, 32'hC0, 0, 1);  // push coincides with a pop at full
    req = 0;
    apb(0, A_STATUS, 0, 0, 0);
    drain();
    @(negedge clk);
    chk("empty_after_drain", empty, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) apb(1, A_FIFO, $urandom, 0, 0);
    apb(1, A_CMD, 32'h4, 0, 0);
    apb(0, A_STATUS, 0, 0, 0);
    apb(1, A_CMD, 32'h3, 0, 0);
    apb(1, A_CMD, 32'h0, 0, 0);
    apb(0, A_STATUS, 0, 0, 0);

    apb(0, 32'h8c00_0800, 0, 0, 0);
    apb(0, DUT_END_ADDRESS, 0, 0, 0);
    apb(0, DUT_END_ADDRESS + 32'h4, 0, 0, 0);
    apb(1, DUT_START_ADDRESS - 32'h4, 32'h55, 0, 0);
    apb(1, DUT_START_ADDRESS + 32'h10, 32'h77, 0, 0);

    rand_addr = '{A_CMD, A_STATUS, A_LEVEL, A_FIFO, A_FIFO, DUT_START_ADDRESS + 32'h10,
                  DUT_END_ADDRESS, DUT_END_ADDRESS + 32'h4, 32'h0000_1000};
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, d;
      a = rand_addr[$urandom_range(8, 0)];
      d = $urandom;
      if (a == A_CMD) d = (($urandom_range(3, 0) == 0) ? 32'h4 : 32'h0) | 32'($urandom_range(3, 0));
      apb(1'($urandom), a, d, 1'($urandom), 1'($urandom));
      if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1), 1'($urandom));
    end
    req = 0;
    apb(1, A_CMD, 32'h1, 0, 0);
    drain();

    // Reset in the middle of a LEVEL write access phase.
    apb(1, A_LEVEL, 32'h4321, 0, 0);
    psel = 1; penable = 0; pwrite = 1; paddr = A_LEVEL; pwdata = 32'h5555;
    @(posedge clk); #1;
    penable = 1;
    apb_exp.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk); #2;
    rst_n = 0;
    psel = 0; penable = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("level_after_reset", level, 16'h8000);
    @(posedge clk); #1;
    apb(0, A_LEVEL, 0, 0, 0);
    apb(0, A_STATUS, 0, 0, 0);
    idle(3, 1'b0);

    if (apb_exp.size() != 0) fail_now("apb_response_missing");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
